// File: rtl/hbridge_pwm_multi_if.sv
// Command and drive-pin bundle between the PID scaling stage and hbridge_pwm_multi.
interface hbridge_pwm_multi_if #(
    parameter int unsigned CH    = 2,
    parameter int unsigned CNT_W = 13
);
    logic [CH*(CNT_W+1)-1:0] duty_in;
    logic [CH-1:0]           duty_valid;
    logic [2*CH-1:0]         mode_in;
    logic [CH-1:0]           rpwm;
    logic [CH-1:0]           lpwm;
    logic [CH-1:0]           r_en;
    logic [CH-1:0]           l_en;
    logic [CH-1:0]           wdog_trip;
    logic                    period_start;

    modport master (
        output duty_in, duty_valid, mode_in,
        input  rpwm, lpwm, r_en, l_en, wdog_trip, period_start
    );
    modport slave (
        input  duty_in, duty_valid, mode_in,
        output rpwm, lpwm, r_en, l_en, wdog_trip, period_start
    );
endinterface

// File: rtl/hbridge_pwm_multi.sv
// Multi-channel H-bridge PWM driver: shared carrier, double-buffered signed duty,
// reversal dead-time, coast/brake modes and a per-channel command watchdog.
module hbridge_pwm_multi #(
    parameter int unsigned CH           = 2,
    parameter int unsigned CNT_W        = 13,
    parameter int unsigned PERIOD       = 5000,
    parameter int unsigned DEAD_CYC     = 200,
    parameter int unsigned WDOG_PERIODS = 50
) (
    input logic                aclk,
    input logic                rst_n,
    hbridge_pwm_multi_if.slave bus
);
    localparam int unsigned DUTY_W = CNT_W + 1;
    localparam int unsigned DW     = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int unsigned WW     = (WDOG_PERIODS > 1) ? $clog2(WDOG_PERIODS) : 1;
    localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] PERIOD_MAG  = DUTY_W'(PERIOD);
    localparam logic [DW-1:0]     DEAD_LOAD   = DW'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam logic [WW-1:0]     WDOG_LAST   = WW'((WDOG_PERIODS > 0) ? WDOG_PERIODS - 1 : 0);

    typedef enum logic [1:0] {StOff, StFwd, StRev, StDead} dir_e;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              boundary, ps_q, ps_d;
    logic [DUTY_W-1:0] shadow_q [CH], shadow_d [CH], active_q [CH], active_d [CH];
    logic [DUTY_W-1:0] duty_w [CH], mag_raw [CH], mag [CH];
    logic [1:0]        mode_w [CH], mode_q [CH], mode_d [CH], eff [CH];
    dir_e              state_q [CH], state_d [CH], base [CH];
    logic [DW-1:0]     dead_q [CH], dead_d [CH];
    logic [WW-1:0]     wdog_q [CH], wdog_d [CH];
    logic [CH-1:0]     tgt_rev_q, tgt_rev_d, trip_q, trip_d, hold, new_pos, new_neg;
    logic [CH-1:0]     rpwm_q, rpwm_d, lpwm_q, lpwm_d, ren_q, ren_d, len_q, len_d;

    assign boundary = (cnt_q == PERIOD_LAST);

    always_comb begin
        for (int k = 0; k < CH; k++) begin
            duty_w[k]  = bus.duty_in[k*DUTY_W +: DUTY_W];
            mode_w[k]  = bus.mode_in[2*k +: 2];
            // Two's-complement negate of the most negative code lands above PERIOD and saturates.
            mag_raw[k] = active_q[k][DUTY_W-1] ? (~active_q[k] + 1'b1) : active_q[k];
            mag[k]     = (mag_raw[k] > PERIOD_MAG) ? PERIOD_MAG : mag_raw[k];
        end
    end

    always_comb begin
        cnt_d     = boundary ? '0 : cnt_q + 1'b1;
        ps_d      = (cnt_d == '0);
        tgt_rev_d = tgt_rev_q;
        trip_d    = trip_q;
        rpwm_d    = '0;
        lpwm_d    = '0;
        ren_d     = '0;
        len_d     = '0;
        hold      = '0;
        new_pos   = '0;
        new_neg   = '0;
        for (int k = 0; k < CH; k++) begin
            hold[k]     = (mode_w[k] != 2'b00) || (mode_q[k] != 2'b00);
            shadow_d[k] = bus.duty_valid[k] ? duty_w[k] : shadow_q[k];
            active_d[k] = boundary ? shadow_d[k] : active_q[k];
            new_neg[k]  = active_d[k][DUTY_W-1];
            new_pos[k]  = !active_d[k][DUTY_W-1] && (active_d[k] != '0);
            // Entering coast/brake is immediate; leaving it waits for the carrier boundary.
            mode_d[k]   = (mode_w[k] != 2'b00) ? mode_w[k] : (boundary ? 2'b00 : mode_q[k]);
            eff[k]      = (mode_w[k] != 2'b00) ? mode_w[k] : mode_q[k];

            wdog_d[k] = wdog_q[k];
            if (bus.duty_valid[k]) begin
                wdog_d[k] = '0;
                trip_d[k] = 1'b0;
            end else if ((WDOG_PERIODS != 0) && boundary && !hold[k] && !trip_q[k]) begin
                if (wdog_q[k] == WDOG_LAST) trip_d[k] = 1'b1;
                else                        wdog_d[k] = wdog_q[k] + 1'b1;
            end

            state_d[k] = state_q[k];
            dead_d[k]  = dead_q[k];
            base[k]    = (mode_q[k] != 2'b00) ? StOff : state_q[k];
            if (state_q[k] == StDead) begin
                if (dead_q[k] == '0) state_d[k] = tgt_rev_q[k] ? StRev : StFwd;
                else                 dead_d[k] = dead_q[k] - 1'b1;
            end
            if ((mode_w[k] != 2'b00) || trip_d[k]) begin
                state_d[k] = StOff;
            end else if (boundary) begin
                case (base[k])
                    StOff: begin
                        if (new_pos[k])      state_d[k] = StFwd;
                        else if (new_neg[k]) state_d[k] = StRev;
                    end
                    StFwd, StRev, StDead: begin
                        // Opposite sign to the present (or pending) direction restarts dead-time.
                        if ((new_neg[k] && ((base[k] == StFwd) ||
                                            (base[k] == StDead && !tgt_rev_q[k]))) ||
                            (new_pos[k] && ((base[k] == StRev) ||
                                            (base[k] == StDead && tgt_rev_q[k])))) begin
                            tgt_rev_d[k] = new_neg[k];
                            if (DEAD_CYC == 0) begin
                                state_d[k] = new_neg[k] ? StRev : StFwd;
                            end else begin
                                state_d[k] = StDead;
                                dead_d[k]  = DEAD_LOAD;
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (eff[k] == 2'b10) begin
                ren_d[k] = 1'b1;
                len_d[k] = 1'b1;
            end else if ((eff[k] == 2'b00) && !trip_d[k]) begin
                ren_d[k]  = 1'b1;
                len_d[k]  = 1'b1;
                rpwm_d[k] = (state_q[k] == StFwd) && ({1'b0, cnt_q} < mag[k]);
                lpwm_d[k] = (state_q[k] == StRev) && ({1'b0, cnt_q} < mag[k]);
            end
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ps_q      <= 1'b0;
            tgt_rev_q <= '0;
            trip_q    <= '0;
            rpwm_q    <= '0;
            lpwm_q    <= '0;
            ren_q     <= '0;
            len_q     <= '0;
            for (int k = 0; k < CH; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
                mode_q[k]   <= 2'b00;
                state_q[k]  <= StOff;
                dead_q[k]   <= '0;
                wdog_q[k]   <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            ps_q      <= ps_d;
            tgt_rev_q <= tgt_rev_d;
            trip_q    <= trip_d;
            rpwm_q    <= rpwm_d;
            lpwm_q    <= lpwm_d;
            ren_q     <= ren_d;
            len_q     <= len_d;
            for (int k = 0; k < CH; k++) begin
                shadow_q[k] <= shadow_d[k];
                active_q[k] <= active_d[k];
                mode_q[k]   <= mode_d[k];
                state_q[k]  <= state_d[k];
                dead_q[k]   <= dead_d[k];
                wdog_q[k]   <= wdog_d[k];
            end
        end
    end

    assign bus.rpwm         = rpwm_q;
    assign bus.lpwm         = lpwm_q;
    assign bus.r_en         = ren_q;
    assign bus.l_en         = len_q;
    assign bus.wdog_trip    = trip_q;
    assign bus.period_start = ps_q;
endmodule
